// File: rtl/iob_uart_host_pkg.sv
// Shared types and constants for the IOb UART host.
// Contents: controller state enum, UART CSR byte addresses, CSR bit indices,
//   bus field widths.
package iob_uart_host_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned BYTE_W = 8;

  localparam logic [ADDR_W-1:0] CSR_CFG_ADDR  = 3'd0;
  localparam logic [ADDR_W-1:0] CSR_DATA_ADDR = 3'd4;

  localparam int unsigned TX_RDY = 0;
  localparam int unsigned RX_RDY = 1;
  localparam int unsigned TX_EN  = 16;
  localparam int unsigned RX_EN  = 17;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_GAP,
    ST_POLL,
    ST_POLL_WAIT,
    ST_DECIDE,
    ST_RXRD,
    ST_RX_WAIT,
    ST_TXWR,
    ST_ERR
  } state_e;

endpackage

// File: rtl/iob_uart_host_fifo.sv
// Synchronous byte FIFO holding TX bytes until the UART can take them.
// Ports: clk_i/rst_i (sync, active-high), push_i/wdata_i write side,
//   pop_i/rdata_o read side (rdata_o shows the head), full_o/empty_o flags.
// Push while full and pop while empty are ignored.
module iob_uart_host_fifo
  import iob_uart_host_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned FIFO_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned DEPTH = 1 << FIFO_W;
  localparam int unsigned CNT_W = FIFO_W + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [FIFO_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q;
  logic              push_ok, pop_ok;

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;
  assign count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

  // Flags registered from next count so they are clean register outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + FIFO_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage is not reset; pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/iob_uart_host.sv
// IOb master driving the UART CSR port: configures the UART after reset,
// then polls status and moves bytes between the UART and two byte streams.
// Ports: clk_i/rst_i (sync, active-high); iob_* request/response to the UART;
//   tx_data_i/tx_valid_i/tx_ready_o TX byte stream into a small FIFO;
//   rx_data_o/rx_valid_o/rx_ready_i RX byte stream from a 1-entry buffer;
//   err_o sticky timeout flag.
// Build option IOB_UART_HOST_TIMEOUT_EN: bounds every bus wait by TIMEOUT
//   cycles and parks in an error state; otherwise waits are unbounded and
//   err_o is tied low.
module iob_uart_host
  import iob_uart_host_pkg::*;
#(
  parameter logic [15:0] DIV      = 16'd434,
  parameter int unsigned POLL_GAP = 8,
  parameter int unsigned FIFO_W   = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              iob_valid_o,
  output logic [ADDR_W-1:0] iob_addr_o,
  output logic [DATA_W-1:0] iob_wdata_o,
  output logic [STRB_W-1:0] iob_wstrb_o,
  input  logic              iob_rvalid_i,
  input  logic [DATA_W-1:0] iob_rdata_i,
  input  logic              iob_ready_i,
  input  logic [BYTE_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [BYTE_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              err_o
);

  localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [1:0]        stat_q, stat_d;
  logic              prio_q, prio_d;
  logic              rx_full_q;
  logic [BYTE_W-1:0] rx_data_q;
  logic              rx_load, fifo_pop, fifo_push;
  logic              rx_elig, tx_elig;
  logic [BYTE_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] cfg_word;
  logic              unused_rdata;

  assign unused_rdata = ^iob_rdata_i[DATA_W-1:BYTE_W];

  always_comb begin
    cfg_word         = '0;
    cfg_word[RX_EN]  = 1'b1;
    cfg_word[TX_EN]  = 1'b1;
    cfg_word[15:0]   = DIV;
  end

`ifdef IOB_UART_HOST_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q;
  logic             waiting;
  assign tx_ready_o = ~fifo_full & ~err_q;
  assign err_o      = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^32'(TIMEOUT);
  assign tx_ready_o = ~fifo_full;
  assign err_o      = 1'b0;
`endif

  assign fifo_push = tx_valid_i & tx_ready_o;

  iob_uart_host_fifo #(
    .WIDTH  (BYTE_W),
    .FIFO_W (FIFO_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i (tx_data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Controller state and registered bus request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      gap_q   <= '0;
      stat_q  <= '0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      gap_q   <= gap_d;
      stat_q  <= stat_d;
      prio_q  <= prio_d;
    end
  end

  // Next-state and request logic; a request is raised on entry to a bus
  // state and dropped the cycle after it is accepted.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    gap_d    = '0;
    stat_d   = stat_q;
    prio_d   = prio_q;
    fifo_pop = 1'b0;
    rx_load  = 1'b0;
    rx_elig  = stat_q[RX_RDY] & ~rx_full_q;
    tx_elig  = stat_q[TX_RDY] & ~fifo_empty;

    case (state_q)
      ST_INIT: begin
        valid_d = 1'b1;
        addr_d  = CSR_CFG_ADDR;
        wdata_d = cfg_word;
        wstrb_d = '1;
        if (valid_q && iob_ready_i) begin
          valid_d = 1'b0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(POLL_GAP - 1)) begin
          state_d = ST_POLL;
          valid_d = 1'b1;
          addr_d  = CSR_CFG_ADDR;
          wdata_d = '0;
          wstrb_d = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_POLL: begin
        if (iob_ready_i) begin
          valid_d = 1'b0;
          if (iob_rvalid_i) begin
            stat_d  = {iob_rdata_i[RX_RDY], iob_rdata_i[TX_RDY]};
            state_d = ST_DECIDE;
          end else begin
            state_d = ST_POLL_WAIT;
          end
        end
      end
      ST_POLL_WAIT: begin
        if (iob_rvalid_i) begin
          stat_d  = {iob_rdata_i[RX_RDY], iob_rdata_i[TX_RDY]};
          state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        // prio_q=0 favours RX when both sides are eligible, then flips.
        if (rx_elig && (!tx_elig || !prio_q)) begin
          state_d = ST_RXRD;
          valid_d = 1'b1;
          addr_d  = CSR_DATA_ADDR;
          wdata_d = '0;
          wstrb_d = '0;
        end else if (tx_elig) begin
          state_d = ST_TXWR;
          valid_d = 1'b1;
          addr_d  = CSR_DATA_ADDR;
          wdata_d = {{(DATA_W-BYTE_W){1'b0}}, fifo_rdata};
          wstrb_d = 4'b0001;
        end else begin
          state_d = ST_GAP;
        end
        if (rx_elig && tx_elig) prio_d = ~prio_q;
      end
      ST_RXRD: begin
        if (iob_ready_i) begin
          valid_d = 1'b0;
          if (iob_rvalid_i) begin
            rx_load = 1'b1;
            state_d = ST_GAP;
          end else begin
            state_d = ST_RX_WAIT;
          end
        end
      end
      ST_RX_WAIT: begin
        if (iob_rvalid_i) begin
          rx_load = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_TXWR: begin
        if (iob_ready_i) begin
          valid_d  = 1'b0;
          fifo_pop = 1'b1;
          state_d  = ST_GAP;
        end
      end
      ST_ERR: begin
        valid_d = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_INIT;
      end
    endcase

`ifdef IOB_UART_HOST_TIMEOUT_EN
    tmo_d   = '0;
    waiting = (state_q == ST_INIT) || (state_q == ST_POLL) ||
              (state_q == ST_POLL_WAIT) || (state_q == ST_RXRD) ||
              (state_q == ST_RX_WAIT) || (state_q == ST_TXWR);
    // Counter restarts on every state change; stalling TIMEOUT+1 cycles parks.
    if (waiting && (state_d == state_q)) begin
      if (tmo_q == TMO_W'(TIMEOUT)) begin
        state_d  = ST_ERR;
        valid_d  = 1'b0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
`endif
  end

`ifdef IOB_UART_HOST_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_q | (state_d == ST_ERR);
    end
  end
`endif

  // Single-entry RX buffer; only loaded when empty, so it cannot overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_full_q <= 1'b0;
      rx_data_q <= '0;
    end else if (rx_load) begin
      rx_full_q <= 1'b1;
      rx_data_q <= iob_rdata_i[BYTE_W-1:0];
    end else if (rx_full_q && rx_ready_i) begin
      rx_full_q <= 1'b0;
    end
  end

  assign iob_valid_o = valid_q;
  assign iob_addr_o  = addr_q;
  assign iob_wdata_o = wdata_q;
  assign iob_wstrb_o = wstrb_q;
  assign rx_valid_o  = rx_full_q;
  assign rx_data_o   = rx_data_q;

endmodule
